// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI write controller: the controller FSM state
// encoding, the frame geometry, the peripheral register map and a helper
// that assembles the 16-bit write frame.
// ---------------------------------------------------------------------------
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } spi_state_e;

    localparam int   FRAME_W   = 16;
    localparam logic WRITE_BIT = 1'b1;

    // Register map of the peripheral on the other end of the link
    localparam logic [6:0] ADDR_OUT_7_0   = 7'h00;
    localparam logic [6:0] ADDR_OUT_15_8  = 7'h01;
    localparam logic [6:0] ADDR_PWM_7_0   = 7'h02;
    localparam logic [6:0] ADDR_PWM_15_8  = 7'h03;
    localparam logic [6:0] ADDR_PWM_DUTY  = 7'h04;

    // A write frame is sent MSB first: write flag, 7-bit address, 8-bit data
    function automatic logic [FRAME_W-1:0] build_frame(input logic [6:0] addr,
                                                       input logic [7:0] data);
        return {WRITE_BIT, addr, data};
    endfunction

endpackage

// File: rtl/spi_phase_timer.sv
// ---------------------------------------------------------------------------
// spi_phase_timer
// Down-counter that divides a frame into phases of SCLK_HALF clk cycles.
// Ports:
//   clk, rst_n    - system clock, asynchronous active-low reset
//   load_i        - start a new frame: counter loads SCLK_HALF-1
//   run_i         - a frame is in progress; counter keeps cycling
//   phase_end_o   - last cycle of the current phase (counter at zero)
//   count_o       - current counter value
// ---------------------------------------------------------------------------
module spi_phase_timer
    import spi_pkg::*;
#(
    parameter int SCLK_HALF = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic       run_i,
    output logic       phase_end_o,
    output logic [7:0] count_o
);

    localparam logic [7:0] RELOAD = 8'(SCLK_HALF - 1);

    logic [7:0] count_q;

    // Outside a frame the counter parks at zero so every frame starts from
    // a known phase alignment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 8'd0;
        end else if (load_i) begin
            count_q <= RELOAD;
        end else if (run_i) begin
            count_q <= (count_q == 8'd0) ? RELOAD : count_q - 8'd1;
        end else begin
            count_q <= 8'd0;
        end
    end

    assign phase_end_o = run_i && (count_q == 8'd0);
    assign count_o     = count_q;

endmodule

// File: rtl/spi_controller.sv
// ---------------------------------------------------------------------------
// spi_controller
// SPI mode-0 write master. Accepts one {addr, data} request at a time and
// shifts a 16-bit frame {1, addr[6:0], data[7:0]} out MSB first.
// Ports:
//   clk, rst_n    - system clock, asynchronous active-low reset
//   req_valid     - write request present
//   req_ready     - controller idle and able to accept a request
//   req_addr      - 7-bit target register address
//   req_data      - 8-bit write data
//   done          - one-cycle pulse when a frame completes
//   sclk          - SPI clock, idles low
//   COPI          - serial data towards the peripheral
//   cs            - active-low chip select, idles high
// ---------------------------------------------------------------------------
module spi_controller
    import spi_pkg::*;
#(
    parameter int SCLK_HALF = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_data,
    output logic       done,
    output logic       sclk,
    output logic       COPI,
    output logic       cs
);

    spi_state_e         state_q;
    logic               cs_q;
    logic               sclk_q;
    logic               copi_q;
    logic               done_q;
    logic               ready_q;
    logic [3:0]         bit_q;
    logic [FRAME_W-1:0] shreg_q;

    logic               accept;
    logic               phase_end;
    logic [7:0]         phase_count;

    assign accept = req_valid && ready_q;

    spi_phase_timer #(
        .SCLK_HALF (SCLK_HALF)
    ) u_phase_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (accept),
        .run_i       (state_q != IDLE),
        .phase_end_o (phase_end),
        .count_o     (phase_count)
    );

    // shreg_q holds the bits still to be sent, left-aligned; the bit on COPI
    // has already been removed from it. GAP leaves one cycle early so that
    // req_ready is already high on the edge 34*SCLK_HALF after the accept,
    // letting a held request restart exactly one frame period later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b0;
            copi_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
            bit_q   <= 4'd0;
            shreg_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= SETUP;
                        ready_q <= 1'b0;
                        cs_q    <= 1'b0;
                        bit_q   <= 4'd0;
                        copi_q  <= build_frame(req_addr, req_data)[FRAME_W-1];
                        shreg_q <= {build_frame(req_addr, req_data)[FRAME_W-2:0], 1'b0};
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                SETUP: begin
                    if (phase_end) begin
                        state_q <= SHIFT;
                        sclk_q  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (phase_end) begin
                        if (!sclk_q) begin
                            sclk_q <= 1'b1;
                        end else begin
                            sclk_q <= 1'b0;
                            if (bit_q == 4'd15) begin
                                state_q <= HOLD;
                            end else begin
                                bit_q   <= bit_q + 4'd1;
                                copi_q  <= shreg_q[FRAME_W-1];
                                shreg_q <= {shreg_q[FRAME_W-2:0], 1'b0};
                            end
                        end
                    end
                end
                HOLD: begin
                    if (phase_end) begin
                        state_q <= GAP;
                        cs_q    <= 1'b1;
                        copi_q  <= 1'b0;
                        done_q  <= 1'b1;
                        bit_q   <= 4'd0;
                    end
                end
                GAP: begin
                    if (phase_count == 8'd1) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = ready_q;
    assign done      = done_q;
    assign sclk      = sclk_q;
    assign COPI      = copi_q;
    assign cs        = cs_q;

endmodule

// File: tb/tb_spi_controller.sv
// ---------------------------------------------------------------------------
// tb_spi_controller
// Directed bench for spi_controller. Three controllers share one clock and
// reset: index 0 runs with SCLK_HALF=4, index 1 with 3, index 2 with 255.
// A small receiving peripheral model listens to index 0 and keeps the five
// registers of the register map.
// ---------------------------------------------------------------------------
module tb_spi_controller;

   logic       clock = 1'b0;
   logic       resetN = 1'b0;
   logic [2:0] reqValid = 3'b000;
   logic [6:0] reqAddr [3];
   logic [7:0] reqData [3];
   logic [2:0] readyOut;
   logic [2:0] doneOut;
   logic [2:0] sclkOut;
   logic [2:0] copiOut;
   logic [2:0] csOut;

   int checks = 0;
   int errors = 0;

   // Receiver bookkeeping, one slot per controller
   logic [15:0] rxShift [3];
   int          rxCnt [3];
   logic [15:0] lastWord [3];
   int          frameCount [3];
   int          doneCount [3];
   logic [2:0]  prevSclk = 3'b000;
   logic [2:0]  prevCs = 3'b111;
   int          cyc = 0;
   logic [7:0]  periph [5];
   logic [15:0] rxQ [$];
   int          stampQ [$];

   spi_controller #(.SCLK_HALF(4)) u_spi4 (
      .clk(clock), .rst_n(resetN), .req_valid(reqValid[0]), .req_ready(readyOut[0]),
      .req_addr(reqAddr[0]), .req_data(reqData[0]), .done(doneOut[0]),
      .sclk(sclkOut[0]), .COPI(copiOut[0]), .cs(csOut[0]));

   spi_controller #(.SCLK_HALF(3)) u_spi3 (
      .clk(clock), .rst_n(resetN), .req_valid(reqValid[1]), .req_ready(readyOut[1]),
      .req_addr(reqAddr[1]), .req_data(reqData[1]), .done(doneOut[1]),
      .sclk(sclkOut[1]), .COPI(copiOut[1]), .cs(csOut[1]));

   spi_controller #(.SCLK_HALF(255)) u_spi255 (
      .clk(clock), .rst_n(resetN), .req_valid(reqValid[2]), .req_ready(readyOut[2]),
      .req_addr(reqAddr[2]), .req_data(reqData[2]), .done(doneOut[2]),
      .sclk(sclkOut[2]), .COPI(copiOut[2]), .cs(csOut[2]));

   // Free-running clock, 10 time units per period
   initial begin
      forever #5 clock = ~clock;
   end

   // Peripheral model sampled on the falling clk edge: shifts COPI in on each
   // sclk rise while cs is low and commits a complete 16-bit write when cs
   // rises. A frame cut short (fewer than 16 bits) is thrown away.
   initial begin
      for (int k = 0; k < 3; k++) begin
         rxShift[k] = 16'h0; rxCnt[k] = 0; lastWord[k] = 16'h0;
         frameCount[k] = 0; doneCount[k] = 0;
      end
      for (int r = 0; r < 5; r++) periph[r] = 8'h00;
      forever begin
         @(negedge clock);
         cyc++;
         for (int k = 0; k < 3; k++) begin
            if (csOut[k] === 1'b0 && sclkOut[k] === 1'b1 && prevSclk[k] === 1'b0) begin
               rxShift[k] = {rxShift[k][14:0], copiOut[k]};
               rxCnt[k]++;
            end
            if (csOut[k] === 1'b1 && prevCs[k] === 1'b0) begin
               if (rxCnt[k] == 16) begin
                  lastWord[k] = rxShift[k];
                  frameCount[k]++;
                  if (k == 0) begin
                     rxQ.push_back(rxShift[k]);
                     stampQ.push_back(cyc);
                     if (rxShift[k][15] && int'(rxShift[k][14:8]) < 5)
                        periph[int'(rxShift[k][14:8])] = rxShift[k][7:0];
                  end
               end
            end
            if (csOut[k] === 1'b0 && prevCs[k] === 1'b1) rxCnt[k] = 0;
            if (doneOut[k] === 1'b1) doneCount[k]++;
         end
         prevSclk = sclkOut;
         prevCs = csOut;
      end
   end

   // One comparison: counts it and reports a mismatch with tag and values
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Wait, on falling edges, until controller s shows req_ready
   task automatic waitReady(input int s, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20000; i++) begin
         @(negedge clock);
         if (readyOut[s] === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Present one request and return #1 after its accept edge (edge 0)
   task automatic startFrame(input int s, input logic [6:0] a, input logic [7:0] d);
      bit ok;
      waitReady(s, ok);
      checkOutput("ready_wait", 32'(ok), 32'd1);
      reqValid[s] = 1'b1; reqAddr[s] = a; reqData[s] = d;
      @(posedge clock); #1;
      reqValid[s] = 1'b0;
   endtask

   // Full frame with edge-by-edge timing checks against the timing formula:
   // sclk high on [H+2iH, 2H+2iH), cs low until 33H, done at 33H, COPI
   // advancing every 2H, req_ready back by edge 34H.
   task automatic applyStimulus(input int s, input int h, input logic [6:0] a, input logic [7:0] d);
      int badCs = 0, badSclk = 0, badCopi = 0, badDone = 0, badReady = 0;
      int framesBefore, bitIdx;
      logic [15:0] expWord;
      logic expCs, expSclk, expCopi, expDone, expReady;
      expWord = {1'b1, a, d};
      framesBefore = frameCount[s];
      startFrame(s, a, d);
      for (int e = 0; e <= 34 * h; e++) begin
         if (e > 0) begin
            @(posedge clock); #1;
         end
         bitIdx = e / (2 * h);
         if (bitIdx > 15) bitIdx = 15;
         expCs    = (e >= 33 * h);
         expSclk  = (e >= h) && (e < 33 * h) && (((e - h) / h) % 2 == 0);
         expCopi  = (e < 33 * h) ? expWord[15 - bitIdx] : 1'b0;
         expDone  = (e == 33 * h);
         expReady = (e >= 34 * h - 1);
         if (csOut[s] !== expCs) badCs++;
         if (sclkOut[s] !== expSclk) badSclk++;
         if (copiOut[s] !== expCopi) badCopi++;
         if (doneOut[s] !== expDone) badDone++;
         if (readyOut[s] !== expReady) badReady++;
      end
      checkOutput("cs_timing_bad_edges", 32'(badCs), 32'd0);
      checkOutput("sclk_timing_bad_edges", 32'(badSclk), 32'd0);
      checkOutput("copi_timing_bad_edges", 32'(badCopi), 32'd0);
      checkOutput("done_timing_bad_edges", 32'(badDone), 32'd0);
      checkOutput("ready_timing_bad_edges", 32'(badReady), 32'd0);
      checkOutput("rx_word", 32'(lastWord[s]), 32'(expWord));
      checkOutput("rx_frames", 32'(frameCount[s] - framesBefore), 32'd1);
   endtask

   // Directed sequence
   initial begin
      int doneBase, frameBase, qBase;
      bit got;
      logic [6:0] bAddr [3];
      logic [7:0] bData [3];
      bAddr[0] = 7'h00; bAddr[1] = 7'h01; bAddr[2] = 7'h04;
      bData[0] = 8'hFF; bData[1] = 8'h0F; bData[2] = 8'h80;
      for (int k = 0; k < 3; k++) begin
         reqAddr[k] = 7'h00; reqData[k] = 8'h00;
      end

      // Reset state, then req_ready on the first edge after release
      repeat (3) @(negedge clock);
      checkOutput("reset_cs", 32'(csOut), 32'h7);
      checkOutput("reset_sclk", 32'(sclkOut), 32'h0);
      checkOutput("reset_copi", 32'(copiOut), 32'h0);
      checkOutput("reset_done", 32'(doneOut), 32'h0);
      checkOutput("reset_ready", 32'(readyOut), 32'h0);
      resetN = 1'b1;
      @(posedge clock); #1;
      checkOutput("ready_after_reset", 32'(readyOut), 32'h7);

      // Basic frame addr 0x04 data 0xA5 -> 0x84A5
      applyStimulus(0, 4, 7'h04, 8'hA5);
      checkOutput("periph_reg4_a5", 32'(periph[4]), 32'hA5);

      // Loopback writes into the peripheral model
      applyStimulus(0, 4, 7'h00, 8'hFF);
      applyStimulus(0, 4, 7'h01, 8'h0F);
      applyStimulus(0, 4, 7'h04, 8'h80);
      checkOutput("periph_reg0", 32'(periph[0]), 32'hFF);
      checkOutput("periph_reg1", 32'(periph[1]), 32'h0F);
      checkOutput("periph_reg2", 32'(periph[2]), 32'h00);
      checkOutput("periph_reg3", 32'(periph[3]), 32'h00);
      checkOutput("periph_reg4", 32'(periph[4]), 32'h80);

      // Request pulsed at edge 10 of an active frame must be dropped
      doneBase = doneCount[0];
      frameBase = frameCount[0];
      startFrame(0, 7'h03, 8'h00);
      repeat (9) @(posedge clock);
      @(negedge clock);
      checkOutput("busy_ready_low", 32'(readyOut[0]), 32'd0);
      reqValid[0] = 1'b1; reqAddr[0] = 7'h02; reqData[0] = 8'h11;
      @(posedge clock); #1;
      reqValid[0] = 1'b0;
      repeat (200) @(posedge clock);
      #1;
      checkOutput("busy_done_pulses", 32'(doneCount[0] - doneBase), 32'd1);
      checkOutput("busy_frames", 32'(frameCount[0] - frameBase), 32'd1);
      checkOutput("busy_word", 32'(lastWord[0]), 32'h8300);
      checkOutput("busy_reg2_unchanged", 32'(periph[2]), 32'h00);

      // Reset asserted at edge 40 of a frame: outputs drop at once, frame lost
      doneBase = doneCount[0];
      frameBase = frameCount[0];
      startFrame(0, 7'h02, 8'h66);
      repeat (40) @(posedge clock);
      #2;
      resetN = 1'b0;
      #1;
      checkOutput("midreset_cs", 32'(csOut[0]), 32'd1);
      checkOutput("midreset_sclk", 32'(sclkOut[0]), 32'd0);
      checkOutput("midreset_copi", 32'(copiOut[0]), 32'd0);
      checkOutput("midreset_ready", 32'(readyOut[0]), 32'd0);
      repeat (3) @(negedge clock);
      resetN = 1'b1;
      @(posedge clock); #1;
      checkOutput("midreset_ready_after", 32'(readyOut), 32'h7);
      repeat (200) @(posedge clock);
      #1;
      checkOutput("midreset_no_done", 32'(doneCount[0] - doneBase), 32'd0);
      checkOutput("midreset_no_frame", 32'(frameCount[0] - frameBase), 32'd0);
      checkOutput("midreset_reg2", 32'(periph[2]), 32'h00);
      applyStimulus(0, 4, 7'h01, 8'h0F);

      // Back-to-back with req_valid held high for three requests
      qBase = rxQ.size();
      for (int r = 0; r < 3; r++) begin
         reqAddr[0] = bAddr[r]; reqData[0] = bData[r]; reqValid[0] = 1'b1;
         got = 1'b0;
         for (int i = 0; i < 1000; i++) begin
            @(negedge clock);
            if (readyOut[0] === 1'b1) begin
               got = 1'b1;
               break;
            end
         end
         checkOutput("b2b_accept", 32'(got), 32'd1);
         @(posedge clock); #1;
      end
      reqValid[0] = 1'b0;
      for (int i = 0; i < 1000 && rxQ.size() < qBase + 3; i++) @(posedge clock);
      checkOutput("b2b_frames", 32'(rxQ.size() - qBase), 32'd3);
      if (rxQ.size() >= qBase + 3) begin
         for (int r = 0; r < 3; r++)
            checkOutput("b2b_word", 32'(rxQ[qBase + r]), 32'({1'b1, bAddr[r], bData[r]}));
         checkOutput("b2b_gap_1", 32'(stampQ[qBase + 1] - stampQ[qBase]), 32'd136);
         checkOutput("b2b_gap_2", 32'(stampQ[qBase + 2] - stampQ[qBase + 1]), 32'd136);
      end
      checkOutput("final_reg0", 32'(periph[0]), 32'hFF);
      checkOutput("final_reg1", 32'(periph[1]), 32'h0F);
      checkOutput("final_reg4", 32'(periph[4]), 32'h80);

      // Extreme half-periods
      applyStimulus(1, 3, 7'h03, 8'h3C);
      applyStimulus(2, 255, 7'h03, 8'h3C);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
